// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: execute-stage branch/jump resolution with a fetch-stage
// branch history table of 2-bit saturating counters.
// Resolution (PCSrc, flush) and the fetch prediction are combinational; the
// table updates on the rising edge after a legal, non-stalled branch resolves.
// Optional feature macro: BRANCH_PERF_CNT_EN adds branch_count and
// mispredict_count performance counters.
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            predict_taken_f,
`ifdef BRANCH_PERF_CNT_EN
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count,
`endif
  input  logic            valid_e,
  input  logic            stall_e,
  input  logic [6:0]      opcode_e,
  input  logic [2:0]      func3_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic            predicted_taken_e,
  input  logic            ZeroFlag,
  input  logic            NegativeFlag,
  input  logic            UnsignedLess,
  output logic [1:0]      PCSrc,
  output logic            flush
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SEL_SEQ     = 2'b00;
  localparam logic [1:0] SEL_BRANCH  = 2'b01;
  localparam logic [1:0] SEL_RECOVER = 2'b10;
  localparam logic [1:0] SEL_JUMP    = 2'b11;

  // Saturating 2-bit counter step: up on taken, down on not-taken, no wrap.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]          bht_r [BHT_ENTRIES];
  logic [IDX_BITS-1:0] idx_f_s;
  logic [IDX_BITS-1:0] idx_e_s;
  logic                legal_br_s;
  logic                is_jump_s;
  logic                taken_act_s;
  logic                active_s;
  logic                upd_s;
  logic [1:0]          pcsrc_s;
  logic                flush_s;
  logic                unused_pc_bits_s;

  // Word-aligned PCs index the table; byte-offset and upper bits are ignored.
  assign idx_f_s = pc_f[IDX_BITS+1:2];
  assign idx_e_s = pc_e[IDX_BITS+1:2];
  assign unused_pc_bits_s = ^{pc_f[XLEN-1:IDX_BITS+2], pc_f[1:0],
                              pc_e[XLEN-1:IDX_BITS+2], pc_e[1:0]};

  // Only an unstalled valid instruction outside reset may redirect or train.
  assign active_s = valid_e & ~stall_e & ~rst;
  assign upd_s    = active_s & legal_br_s;

  // Decode instruction class and evaluate the actual branch outcome.
  always_comb begin
    legal_br_s  = 1'b0;
    is_jump_s   = 1'b0;
    taken_act_s = 1'b0;
    case (opcode_e)
      OP_BRANCH: begin
        legal_br_s = 1'b1;
        case (func3_e)
          3'b000:  taken_act_s = ZeroFlag;
          3'b001:  taken_act_s = ~ZeroFlag;
          3'b100:  taken_act_s = NegativeFlag;
          3'b101:  taken_act_s = ~NegativeFlag;
          3'b110:  taken_act_s = UnsignedLess;
          3'b111:  taken_act_s = ~UnsignedLess;
          default: begin
            legal_br_s  = 1'b0;
            taken_act_s = 1'b0;
          end
        endcase
      end
      OP_JAL, OP_JALR: begin
        is_jump_s = 1'b1;
      end
      default: begin
        is_jump_s = 1'b0;
      end
    endcase
  end

  // Pick the next-PC source and flush; correct predictions need no redirect.
  always_comb begin
    pcsrc_s = SEL_SEQ;
    flush_s = 1'b0;
    if (!active_s) begin
      pcsrc_s = SEL_SEQ;
      flush_s = 1'b0;
    end else if (is_jump_s) begin
      pcsrc_s = SEL_JUMP;
      flush_s = 1'b1;
    end else if (legal_br_s) begin
      if (taken_act_s && !predicted_taken_e) begin
        pcsrc_s = SEL_BRANCH;
        flush_s = 1'b1;
      end else if (!taken_act_s && predicted_taken_e) begin
        pcsrc_s = SEL_RECOVER;
        flush_s = 1'b1;
      end else begin
        pcsrc_s = SEL_SEQ;
        flush_s = 1'b0;
      end
    end else begin
      pcsrc_s = SEL_SEQ;
      flush_s = 1'b0;
    end
  end

  assign PCSrc           = pcsrc_s;
  assign flush           = flush_s;
  assign predict_taken_f = ~rst & bht_r[idx_f_s][1];

  // Counter table: reset to CNT_INIT, one saturating update per resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= CNT_INIT;
      end
    end else if (upd_s) begin
      bht_r[idx_e_s] <= sat_next(bht_r[idx_e_s], taken_act_s);
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_count_r;
  logic [31:0] mispredict_count_r;

  // Count trained branches and those that had to redirect fetch; wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (upd_s) begin
      branch_count_r <= branch_count_r + 32'd1;
      if (flush_s) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: a driver applies stimulus just after
// each rising edge and queues the reference-model response; a monitor pops and
// compares on the falling edge.
module tb_branch_resolve_bht;

  localparam int ENT = 64;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = 32'd0;
  logic        predict_taken_f;
  logic        valid_e = 1'b0;
  logic        stall_e = 1'b0;
  logic [6:0]  opcode_e = 7'd0;
  logic [2:0]  func3_e = 3'd0;
  logic [31:0] pc_e = 32'd0;
  logic        predicted_taken_e = 1'b0;
  logic        ZeroFlag = 1'b0;
  logic        NegativeFlag = 1'b0;
  logic        UnsignedLess = 1'b0;
  logic [1:0]  PCSrc;
  logic        flush;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(ENT), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .predict_taken_f(predict_taken_f),
`ifdef BRANCH_PERF_CNT_EN
    .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
    .valid_e(valid_e), .stall_e(stall_e), .opcode_e(opcode_e), .func3_e(func3_e),
    .pc_e(pc_e), .predicted_taken_e(predicted_taken_e), .ZeroFlag(ZeroFlag),
    .NegativeFlag(NegativeFlag), .UnsignedLess(UnsignedLess),
    .PCSrc(PCSrc), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pcsrc;
    logic        flush;
    logic        pred;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: counter values as plain integers 0..3.
  int          cnt[ENT];
  int unsigned m_bc = 0;
  int unsigned m_mc = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) cnt[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endfunction

  // Apply one cycle of stimulus and queue what the spec says should appear.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pe, input logic pt,
                       input logic z, input logic n, input logic u,
                       input logic [31:0] pf);
    exp_t e;
    bit   legal;
    bit   taken;
    int   ie;
    @(posedge clk);
    #1;
    rst = r; valid_e = v; stall_e = s; opcode_e = op; func3_e = f3;
    pc_e = pe; predicted_taken_e = pt; ZeroFlag = z; NegativeFlag = n;
    UnsignedLess = u; pc_f = pf;
    e.pcsrc = 2'b00; e.flush = 1'b0; e.pred = 1'b0;
    e.bc = m_bc; e.mc = m_mc;
    if (r) begin
      e.bc = 32'd0; e.mc = 32'd0;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    e.pred = (cnt[(pf >> 2) % ENT] >= 2);
    legal = (op == BR) && (f3 != 3'b010) && (f3 != 3'b011);
    taken = 1'b0;
    if (legal) begin
      case (f3)
        3'b000: taken = z;
        3'b001: taken = !z;
        3'b100: taken = n;
        3'b101: taken = !n;
        3'b110: taken = u;
        default: taken = !u;
      endcase
    end
    if (v && !s) begin
      if (op == JAL || op == JALR) begin
        e.pcsrc = 2'b11; e.flush = 1'b1;
      end else if (legal) begin
        if (taken && !pt) begin e.pcsrc = 2'b01; e.flush = 1'b1; end
        else if (!taken && pt) begin e.pcsrc = 2'b10; e.flush = 1'b1; end
        ie = (pe >> 2) % ENT;
        if (taken) cnt[ie] = (cnt[ie] == 3) ? 3 : cnt[ie] + 1;
        else       cnt[ie] = (cnt[ie] == 0) ? 0 : cnt[ie] - 1;
        m_bc++;
        if (e.flush) m_mc++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] pf);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, pf);
  endtask

  task automatic branch(input logic v, input logic s, input logic [2:0] f3,
                        input logic [31:0] pe, input logic pt, input logic z,
                        input logic [31:0] pf);
    drive(1'b0, v, s, BR, f3, pe, pt, z, 1'b0, 1'b0, pf);
  endtask

  // Monitor: compare outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (PCSrc !== e.pcsrc) begin
          errors++;
          $display("FAIL pcsrc t=%0t got=%b exp=%b", $time, PCSrc, e.pcsrc);
        end
        checks++;
        if (flush !== e.flush) begin
          errors++;
          $display("FAIL flush t=%0t got=%b exp=%b", $time, flush, e.flush);
        end
        checks++;
        if (predict_taken_f !== e.pred) begin
          errors++;
          $display("FAIL predict t=%0t pc_f=%h got=%b exp=%b", $time, pc_f, predict_taken_f, e.pred);
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (branch_count !== e.bc) begin
          errors++;
          $display("FAIL branch_count t=%0t got=%0d exp=%0d", $time, branch_count, e.bc);
        end
        checks++;
        if (mispredict_count !== e.mc) begin
          errors++;
          $display("FAIL mispredict_count t=%0t got=%0d exp=%0d", $time, mispredict_count, e.mc);
        end
`endif
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    ops[0] = BR; ops[1] = BR; ops[2] = BR; ops[3] = BR;
    ops[4] = JAL; ops[5] = JALR; ops[6] = 7'b0110011; ops[7] = 7'b0000011;
    model_reset();

    // Reset held, then release and sweep every index.
    drive(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, JAL, 3'd0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < ENT; i++) idle(i * 4);

    // Train 0x100 toward taken, then saturate.
    for (int i = 0; i < 4; i++) branch(1'b1, 1'b0, 3'b000, 32'h100, 1'b0, 1'b1, 32'h100);
    idle(32'h100);
    // Taken-predicted miss: BNE with equal operands.
    branch(1'b1, 1'b0, 3'b001, 32'h100, 1'b1, 1'b1, 32'h100);
    idle(32'h100);
    // Jumps and gating.
    drive(1'b0, 1'b1, 1'b0, JALR, 3'd0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    drive(1'b0, 1'b0, 1'b0, JALR, 3'd0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    drive(1'b0, 1'b1, 1'b1, JAL, 3'd0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    branch(1'b0, 1'b0, 3'b000, 32'h108, 1'b0, 1'b1, 32'h108);
    for (int i = 0; i < 3; i++) branch(1'b1, 1'b1, 3'b000, 32'h108, 1'b0, 1'b1, 32'h108);
    branch(1'b1, 1'b0, 3'b000, 32'h108, 1'b0, 1'b1, 32'h108);
    idle(32'h108);
    // Illegal func3 and alias lookup during update of the same index.
    branch(1'b1, 1'b0, 3'b010, 32'h10c, 1'b1, 1'b1, 32'h10c);
    branch(1'b1, 1'b0, 3'b011, 32'h10c, 1'b0, 1'b0, 32'h10c);
    branch(1'b1, 1'b0, 3'b001, 32'h100, 1'b1, 1'b1, 32'h200);
    idle(32'h200);
    // Signed/unsigned compares.
    drive(1'b0, 1'b1, 1'b0, BR, 3'b100, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20);
    drive(1'b0, 1'b1, 1'b0, BR, 3'b101, 32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 32'h24);
    drive(1'b0, 1'b1, 1'b0, BR, 3'b110, 32'h28, 1'b0, 1'b0, 1'b0, 1'b1, 32'h28);
    drive(1'b0, 1'b1, 1'b0, BR, 3'b111, 32'h2c, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2c);
    // Reset in the middle of a resolving branch discards its update.
    drive(1'b1, 1'b1, 1'b0, BR, 3'b000, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
    idle(32'h100);

    // Randomised traffic over a small PC range to force aliasing.
    for (int k = 0; k < 2000; k++) begin
      drive(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
            ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
            $urandom & 32'h3ff, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom & 32'h3ff);
    end
    idle(32'd0);

    // Let the monitor drain, with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
